keyboard_expr_queue: RTL and testbench

Parametrised successor to the keyboard token mux. Assembles keyboard tokens into complete `A op B` calculator expressions and queues them for the ALU. Sits between the keyboard decoder (number/operand/strobe) and the ALU. Adds over the previous generation: configurable width, a buffer of completed expressions, a downstream valid/ready handshake, strobe edge detection, operator validation, an abort input and optional result chaining.

---
 rtl/keyboard_expr_queue.sv | 214 +++++++++++++++++++++
 tb/tb_keyboard_expr_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_expr_queue.sv
// Assembles keyboard tokens into {A, op, B} expressions and queues them FIFO for the ALU.
// Optional result chaining (ALU result becomes the next A) is enabled by defining KBD_CHAIN_EN.
module keyboard_expr_queue #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       op_ctrl,
  input  logic [W-1:0]               number,
  input  logic [3:0]                 operand,
  input  logic                       clr,
  input  logic [W-1:0]               result,
  input  logic                       result_valid,
  output logic [W-1:0]               out_a,
  output logic [W-1:0]               out_b,
  output logic [3:0]                 out_op,
  output logic                       valid,
  input  logic                       out_ready,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_A  = 2'd0,
    S_OP = 2'd1,
    S_B  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_strobe_prev;
  logic [W-1:0]    r_a;
  logic [3:0]      r_op;
  logic [W-1:0]    r_mem_a  [DEPTH];
  logic [W-1:0]    r_mem_b  [DEPTH];
  logic [3:0]      r_mem_op [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic [W-1:0]    r_out_a;
  logic [W-1:0]    r_out_b;
  logic [3:0]      r_out_op;
  logic            r_valid;
  logic            r_err;

  logic            w_token;
  logic            w_op_ok;
  logic            w_load_a;
  logic            w_load_res;
  logic            w_load_op;
  logic            w_push_req;
  logic            w_op_err;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [PW-1:0]   w_rd_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : (p + PW'(1));
  endfunction

  assign w_token   = op_ctrl & ~r_strobe_prev;
  assign w_op_ok   = (operand >= 4'hA) && (operand <= 4'hD);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop     = r_valid & out_ready;
  assign w_push    = w_push_req & (~w_full | w_pop);
  assign w_drop    = w_push_req & w_full & ~w_pop;
  assign w_rd_next = ptr_inc(r_rd_ptr);

`ifndef KBD_CHAIN_EN
  logic w_unused_chain;
  assign w_unused_chain = &{1'b0, result, result_valid};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_A;
      r_strobe_prev <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_strobe_prev <= op_ctrl;
    end
  end

  // clr overrides any token on the same edge; result chaining only applies without a token
  always_comb begin
    w_state_nxt = r_state;
    w_load_a    = 1'b0;
    w_load_res  = 1'b0;
    w_load_op   = 1'b0;
    w_push_req  = 1'b0;
    w_op_err    = 1'b0;
    if (clr) begin
      w_state_nxt = S_A;
    end else begin
      case (r_state)
        S_A: begin
          if (w_token) begin
            w_load_a    = 1'b1;
            w_state_nxt = S_OP;
          end
`ifdef KBD_CHAIN_EN
          else if (result_valid) begin
            w_load_res  = 1'b1;
            w_state_nxt = S_OP;
          end
`endif
          else begin
            w_state_nxt = S_A;
          end
        end
        S_OP: begin
          if (w_token && w_op_ok) begin
            w_load_op   = 1'b1;
            w_state_nxt = S_B;
          end else if (w_token) begin
            w_op_err    = 1'b1;
            w_state_nxt = S_OP;
          end else begin
            w_state_nxt = S_OP;
          end
        end
        S_B: begin
          if (w_token) begin
            w_push_req  = 1'b1;
            w_state_nxt = S_A;
          end else begin
            w_state_nxt = S_B;
          end
        end
        default: w_state_nxt = S_A;
      endcase
    end
  end

  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a  <= {W{1'b0}};
      r_op <= 4'h0;
    end else begin
      if (w_load_a) begin
        r_a <= number;
      end else if (w_load_res) begin
        r_a <= result;
      end
      if (w_load_op) begin
        r_op <= operand;
      end
    end
  end

  // The head registers are loaded with whatever entry will be at the front after this edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_a[i]  <= {W{1'b0}};
        r_mem_b[i]  <= {W{1'b0}};
        r_mem_op[i] <= 4'h0;
      end
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_out_a  <= {W{1'b0}};
      r_out_b  <= {W{1'b0}};
      r_out_op <= 4'h0;
    end else begin
      if (w_push) begin
        r_mem_a[r_wr_ptr]  <= r_a;
        r_mem_b[r_wr_ptr]  <= number;
        r_mem_op[r_wr_ptr] <= r_op;
        r_wr_ptr           <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != {CW{1'b0}});
      r_err   <= w_op_err | w_drop;
      if (w_pop && (r_count != CW'(1))) begin
        r_out_a  <= r_mem_a[w_rd_next];
        r_out_b  <= r_mem_b[w_rd_next];
        r_out_op <= r_mem_op[w_rd_next];
      end else if (w_push && (w_pop || (r_count == {CW{1'b0}}))) begin
        r_out_a  <= r_a;
        r_out_b  <= number;
        r_out_op <= r_op;
      end
    end
  end

  assign out_a  = r_out_a;
  assign out_b  = r_out_b;
  assign out_op = r_out_op;
  assign valid  = r_valid;
  assign err    = r_err;
  assign count  = r_count;

endmodule

// File: tb/tb_keyboard_expr_queue.sv
// Directed bench for keyboard_expr_queue (W=8, DEPTH=2): per-cycle vector table plus
// hand sequences for held strobe, clr, reset-during-strobe and result chaining.
module tb_keyboard_expr_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_ctrl;
  logic [7:0] number;
  logic [3:0] operand;
  logic       clr;
  logic [7:0] result;
  logic       result_valid;
  logic [7:0] out_a;
  logic [7:0] out_b;
  logic [3:0] out_op;
  logic       valid;
  logic       out_ready;
  logic       err;
  logic [1:0] count;

  int total = 0;
  int bad   = 0;

  keyboard_expr_queue #(.W(8), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .op_ctrl(op_ctrl), .number(number), .operand(operand),
    .clr(clr), .result(result), .result_valid(result_valid), .out_a(out_a),
    .out_b(out_b), .out_op(out_op), .valid(valid), .out_ready(out_ready),
    .err(err), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       oc;
    logic [7:0] num;
    logic [3:0] opd;
    logic       rdy;
    logic       ev;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [3:0] eop;
    logic       eerr;
    logic [1:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic oc, input logic [7:0] num, input logic [3:0] opd,
                     input logic rdy, input logic ev, input logic [7:0] ea,
                     input logic [7:0] eb, input logic [3:0] eop, input logic eerr,
                     input logic [1:0] ecnt);
    vec_t v;
    v.oc = oc; v.num = num; v.opd = opd; v.rdy = rdy; v.ev = ev;
    v.ea = ea; v.eb = eb; v.eop = eop; v.eerr = eerr; v.ecnt = ecnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] n, input logic [3:0] o, output logic e);
    op_ctrl = 1'b1;
    number  = n;
    operand = o;
    tick();
    e = err;
    op_ctrl = 1'b0;
    tick();
  endtask

  task automatic chk_head(input string nm, input int ev, input int ea, input int eop,
                          input int eb, input int ecnt);
    chk({nm, ".valid"}, valid, ev);
    chk({nm, ".a"}, out_a, ea);
    chk({nm, ".op"}, out_op, eop);
    chk({nm, ".b"}, out_b, eb);
    chk({nm, ".count"}, count, ecnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e;
    // basic expression, overflow drop, pop order
    add(1, 10, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0);
    add(0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0);
    add(1, 0, 4'hB, 0, 0, 0, 0, 4'h0, 0, 0);
    add(0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0);
    add(1, 100, 4'h0, 0, 1, 10, 100, 4'hB, 0, 1);
    add(0, 0, 4'h0, 0, 1, 10, 100, 4'hB, 0, 1);
    add(1, 20, 4'h0, 0, 1, 10, 100, 4'hB, 0, 1);
    add(0, 0, 4'h0, 0, 1, 10, 100, 4'hB, 0, 1);
    add(1, 0, 4'hA, 0, 1, 10, 100, 4'hB, 0, 1);
    add(0, 0, 4'h0, 0, 1, 10, 100, 4'hB, 0, 1);
    add(1, 30, 4'h0, 0, 1, 10, 100, 4'hB, 0, 2);
    add(0, 0, 4'h0, 0, 1, 10, 100, 4'hB, 0, 2);
    add(1, 40, 4'h0, 0, 1, 10, 100, 4'hB, 0, 2);
    add(0, 0, 4'h0, 0, 1, 10, 100, 4'hB, 0, 2);
    add(1, 0, 4'hC, 0, 1, 10, 100, 4'hB, 0, 2);
    add(0, 0, 4'h0, 0, 1, 10, 100, 4'hB, 0, 2);
    add(1, 50, 4'h0, 0, 1, 10, 100, 4'hB, 1, 2);
    add(0, 0, 4'h0, 0, 1, 10, 100, 4'hB, 0, 2);
    add(0, 0, 4'h0, 1, 1, 20, 30, 4'hA, 0, 1);
    add(0, 0, 4'h0, 1, 0, 20, 30, 4'hA, 0, 0);
    add(0, 0, 4'h0, 0, 0, 20, 30, 4'hA, 0, 0);
    // invalid operator then valid one
    add(1, 7, 4'h0, 0, 0, 20, 30, 4'hA, 0, 0);
    add(0, 0, 4'h0, 0, 0, 20, 30, 4'hA, 0, 0);
    add(1, 0, 4'h3, 0, 0, 20, 30, 4'hA, 1, 0);
    add(0, 0, 4'h0, 0, 0, 20, 30, 4'hA, 0, 0);
    add(1, 0, 4'hD, 0, 0, 20, 30, 4'hA, 0, 0);
    add(0, 0, 4'h0, 0, 0, 20, 30, 4'hA, 0, 0);
    add(1, 9, 4'h0, 0, 1, 7, 9, 4'hD, 0, 1);
    add(0, 0, 4'h0, 1, 0, 7, 9, 4'hD, 0, 0);
    add(0, 0, 4'h0, 0, 0, 7, 9, 4'hD, 0, 0);
    // push and pop on the same edge while full
    add(1, 1, 4'h0, 0, 0, 7, 9, 4'hD, 0, 0);
    add(0, 0, 4'h0, 0, 0, 7, 9, 4'hD, 0, 0);
    add(1, 0, 4'hA, 0, 0, 7, 9, 4'hD, 0, 0);
    add(0, 0, 4'h0, 0, 0, 7, 9, 4'hD, 0, 0);
    add(1, 2, 4'h0, 0, 1, 1, 2, 4'hA, 0, 1);
    add(0, 0, 4'h0, 0, 1, 1, 2, 4'hA, 0, 1);
    add(1, 3, 4'h0, 0, 1, 1, 2, 4'hA, 0, 1);
    add(0, 0, 4'h0, 0, 1, 1, 2, 4'hA, 0, 1);
    add(1, 0, 4'hB, 0, 1, 1, 2, 4'hA, 0, 1);
    add(0, 0, 4'h0, 0, 1, 1, 2, 4'hA, 0, 1);
    add(1, 4, 4'h0, 0, 1, 1, 2, 4'hA, 0, 2);
    add(0, 0, 4'h0, 0, 1, 1, 2, 4'hA, 0, 2);
    add(1, 5, 4'h0, 0, 1, 1, 2, 4'hA, 0, 2);
    add(0, 0, 4'h0, 0, 1, 1, 2, 4'hA, 0, 2);
    add(1, 0, 4'hC, 0, 1, 1, 2, 4'hA, 0, 2);
    add(0, 0, 4'h0, 0, 1, 1, 2, 4'hA, 0, 2);
    add(1, 6, 4'h0, 1, 1, 3, 4, 4'hB, 0, 2);
    add(0, 0, 4'h0, 1, 1, 5, 6, 4'hC, 0, 1);
    add(0, 0, 4'h0, 1, 0, 5, 6, 4'hC, 0, 0);
    add(0, 0, 4'h0, 0, 0, 5, 6, 4'hC, 0, 0);

    rst = 1'b0; op_ctrl = 1'b0; number = 8'd0; operand = 4'h0; clr = 1'b0;
    result = 8'd0; result_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk_head("reset", 0, 0, 0, 0, 0);
    chk("reset.err", err, 0);

    foreach (tbl[i]) begin
      op_ctrl = tbl[i].oc; number = tbl[i].num; operand = tbl[i].opd; out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d.valid", i), valid, tbl[i].ev);
      chk($sformatf("vec%0d.a", i), out_a, tbl[i].ea);
      chk($sformatf("vec%0d.b", i), out_b, tbl[i].eb);
      chk($sformatf("vec%0d.op", i), out_op, tbl[i].eop);
      chk($sformatf("vec%0d.err", i), err, tbl[i].eerr);
      chk($sformatf("vec%0d.count", i), count, tbl[i].ecnt);
    end
    op_ctrl = 1'b0; out_ready = 1'b0;
    tick();

    // strobe held for 5 cycles is a single A token, so operand 3 next is an operator error
    op_ctrl = 1'b1; number = 8'd85; operand = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("held.err", err, 0);
    end
    op_ctrl = 1'b0;
    tick();
    strobe(8'd0, 4'h3, e);
    chk("held.in_s_op_err", e, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    strobe(8'd82, 4'h3, e);
    chk("clr.a_err", e, 0);
    strobe(8'd0, 4'hB, e);
    chk("clr.op_err", e, 0);
    strobe(8'd1, 4'h0, e);
    chk_head("clr", 1, 82, 4'hB, 1, 1);

    // reset with strobe high and a non-empty buffer, released while strobe stays high
    op_ctrl = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk_head("async_rst", 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    op_ctrl = 1'b0;
    tick();
    strobe(8'd3, 4'h3, e);
    chk("rst_held.a_err", e, 0);
    strobe(8'd0, 4'hB, e);
    chk("rst_held.op_err", e, 0);
    strobe(8'd2, 4'h0, e);
    chk_head("rst_held", 1, 3, 4'hB, 2, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_head("rst_held_pop", 0, 3, 4'hB, 2, 0);

    // result chaining in S_A
    result = 8'd82; result_valid = 1'b1;
    tick();
    result_valid = 1'b0; result = 8'd0;
`ifdef KBD_CHAIN_EN
    strobe(8'd0, 4'hD, e);
    chk("chain.op_err", e, 0);
    strobe(8'd5, 4'h0, e);
    chk_head("chain", 1, 82, 4'hD, 5, 1);
`else
    strobe(8'd4, 4'h3, e);
    chk("nochain.a_err", e, 0);
    strobe(8'd0, 4'hD, e);
    chk("nochain.op_err", e, 0);
    strobe(8'd5, 4'h0, e);
    chk_head("nochain", 1, 4, 4'hD, 5, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
